// File: rtl/vga_plot_scheduler_if.sv
// Pixel-port bundle between the requesters/clear control and the vga_adapter drive.
// The slave modport is the scheduler; the master side is requesters plus the display sink.
interface vga_plot_scheduler_if;
  logic       clear_start;
  logic       clear_busy;
  logic       r0_valid,  r1_valid;
  logic [8:0] r0_x,      r1_x;
  logic [7:0] r0_y,      r1_y;
  logic [2:0] r0_colour, r1_colour;
  logic       r0_ready,  r1_ready;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [1:0] grant;
  logic       oob_drop;

  modport master (
    output clear_start, r0_valid, r0_x, r0_y, r0_colour,
           r1_valid, r1_x, r1_y, r1_colour,
    input  clear_busy, r0_ready, r1_ready, x, y, colour, plot, grant, oob_drop
  );

  modport slave (
    input  clear_start, r0_valid, r0_x, r0_y, r0_colour,
           r1_valid, r1_x, r1_y, r1_colour,
    output clear_busy, r0_ready, r1_ready, x, y, colour, plot, grant, oob_drop
  );
endinterface

// File: rtl/vga_plot_scheduler.sv
// Round-robin sharing of the vga_adapter write port at one plot per two clocks, plus a
// full-screen clear engine. Define PLOT_BOUNDS_CHECK_EN to discard off-screen requester pixels.
module vga_plot_scheduler #(
  parameter int         X_MAX        = 320,
  parameter int         Y_MAX        = 240,
  parameter logic [2:0] CLEAR_COLOUR = 3'b111
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  vga_plot_scheduler_if.slave  bus
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  localparam logic [8:0] CX_LAST = 9'(X_MAX - 1);
  localparam logic [7:0] CY_LAST = 8'(Y_MAX - 1);

  state_e     state_q, state_d;
  logic       phase_q;
  logic       last_q, last_d;          // 1: r1 won the most recent arbitration
  logic [8:0] cx_q, cx_d;
  logic [7:0] cy_q, cy_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic [1:0] grant_q, grant_d;
  logic       oob_q, oob_d;

  logic       take0, take1, oob;
  logic [8:0] px;
  logic [7:0] py;
  logic [2:0] pc;

  // Ties go to whichever requester did not win last; a lone requester always wins.
  assign take0 = phase_q && (state_q == S_IDLE) && bus.r0_valid && (!bus.r1_valid || last_q);
  assign take1 = phase_q && (state_q == S_IDLE) && bus.r1_valid && (!bus.r0_valid || !last_q);
  assign px    = take1 ? bus.r1_x      : bus.r0_x;
  assign py    = take1 ? bus.r1_y      : bus.r0_y;
  assign pc    = take1 ? bus.r1_colour : bus.r0_colour;

`ifdef PLOT_BOUNDS_CHECK_EN
  localparam logic [9:0] XLIM = 10'(X_MAX);
  localparam logic [8:0] YLIM = 9'(Y_MAX);
  assign oob = ({1'b0, px} >= XLIM) || ({1'b0, py} >= YLIM);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    grant_d  = 2'b00;
    oob_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take0 || take1) begin
          last_d = take1;
          if (oob) begin
            oob_d = 1'b1;
          end else begin
            plot_d   = 1'b1;
            x_d      = px;
            y_d      = py;
            colour_d = pc;
            grant_d  = {take1, take0};
          end
        end
        if (bus.clear_start) begin
          state_d = S_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      S_CLEAR: begin
        if (phase_q) begin
          plot_d   = 1'b1;
          x_d      = cx_q;
          y_d      = cy_q;
          colour_d = CLEAR_COLOUR;
          // Explicit end-of-line / end-of-frame compares; counters never rely on wrap.
          if (cx_q == CX_LAST) begin
            cx_d = '0;
            if (cy_q == CY_LAST) begin
              cy_d    = '0;
              state_d = S_IDLE;
            end else begin
              cy_d = cy_q + 8'd1;
            end
          end else begin
            cx_d = cx_q + 9'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      last_q   <= 1'b1;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      grant_q  <= 2'b00;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= ~phase_q;
      last_q   <= last_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      grant_q  <= grant_d;
      oob_q    <= oob_d;
    end
  end

  assign bus.r0_ready   = take0;
  assign bus.r1_ready   = take1;
  assign bus.clear_busy = (state_q == S_CLEAR);
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;
  assign bus.grant      = grant_q;
  assign bus.oob_drop   = oob_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Bench for vga_plot_scheduler on a reduced screen; a cycle-level reference model predicts
// readys and the registered pixel drive from arbitration rules and a linear clear index.
module tb_vga_plot_scheduler;
  localparam int XM = 32, YM = 24, NPIX = XM * YM;
`ifdef PLOT_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_plot_scheduler_if bus();
  vga_plot_scheduler #(.X_MAX(XM), .Y_MAX(YM), .CLEAR_COLOUR(3'b111)) dut (
    .CLOCK_50(clk), .resetn(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0, cyc = 0;

  // Reference model: phase, mode, round-robin memory, clear index, expected registered drive.
  bit         m_phase, m_idle, m_last;
  int         m_k;
  logic       e_plot, e_oob;
  logic [8:0] e_x;
  logic [7:0] e_y;
  logic [2:0] e_col;
  logic [1:0] e_grant;

  function automatic logic [1:0] exp_ready();
    if (!m_idle || !m_phase) return 2'b00;
    if (bus.r0_valid && bus.r1_valid) return m_last ? 2'b01 : 2'b10;
    return {bus.r1_valid, bus.r0_valid};
  endfunction

  function automatic logic [24:0] got_bus();
    return {bus.plot, bus.x, bus.y, bus.colour, bus.grant, bus.oob_drop, bus.clear_busy};
  endfunction

  function automatic logic [24:0] exp_bus();
    return {e_plot, e_x, e_y, e_col, e_grant, e_oob, ~m_idle};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_idle = 1; m_last = 1; m_k = 0;
    e_plot = 0; e_oob = 0; e_x = 0; e_y = 0; e_col = 0; e_grant = 0;
  endtask

  task automatic step();
    logic [1:0] r;
    bit cs, was_idle;
    logic [8:0] px; logic [7:0] py; logic [2:0] pc;
    r = exp_ready(); cs = bus.clear_start; was_idle = m_idle;
    px = r[1] ? bus.r1_x : bus.r0_x;
    py = r[1] ? bus.r1_y : bus.r0_y;
    pc = r[1] ? bus.r1_colour : bus.r0_colour;
    @(posedge clk);
    e_plot = 0; e_oob = 0; e_grant = 0;
    if (r != 2'b00) begin
      m_last = r[1];
      if (BCHK && (int'(px) >= XM || int'(py) >= YM)) e_oob = 1;
      else begin e_plot = 1; e_x = px; e_y = py; e_col = pc; e_grant = r; end
    end else if (!m_idle && m_phase) begin
      e_plot = 1; e_x = 9'(m_k % XM); e_y = 8'(m_k / XM); e_col = 3'b111;
      m_k++;
      if (m_k == NPIX) m_idle = 1;
    end
    if (was_idle && cs) begin m_idle = 0; m_k = 0; end
    m_phase = !m_phase;
    cyc++;
    #1;
  endtask

  task automatic drive_idle();
    bus.clear_start = 0;
    bus.r0_valid = 0; bus.r0_x = 0; bus.r0_y = 0; bus.r0_colour = 0;
    bus.r1_valid = 0; bus.r1_x = 0; bus.r1_y = 0; bus.r1_colour = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    drive_idle();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive_idle();
    bus.r0_valid = 1; bus.r1_valid = 1; bus.clear_start = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot got=%b exp=0", bus.plot); end
    n_chk++; if ({bus.x, bus.y, bus.colour} !== 20'd0) begin n_fail++; $display("FAIL reset_xyc got=%h exp=0", {bus.x, bus.y, bus.colour}); end
    n_chk++; if ({bus.grant, bus.oob_drop, bus.clear_busy} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.grant, bus.oob_drop, bus.clear_busy}); end
    n_chk++; if ({bus.r1_ready, bus.r0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {bus.r1_ready, bus.r0_ready}); end
    apply_reset();
  endtask

  task automatic test_single();
    int acc_at = -1, nplot = 0;
    bit served;
    apply_reset();
    bus.r0_valid = 1; bus.r0_x = 9'd5; bus.r0_y = 8'd7; bus.r0_colour = 3'b100;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++; if ({bus.r1_ready, bus.r0_ready} !== exp_ready()) begin n_fail++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", cyc, {bus.r1_ready, bus.r0_ready}, exp_ready()); end
      n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL single_bus cyc=%0d got=%h exp=%h", cyc, got_bus(), exp_bus()); end
      if (bus.plot) begin
        nplot++;
        n_chk++; if ({bus.x, bus.y, bus.colour, bus.grant} !== {9'd5, 8'd7, 3'b100, 2'b01}) begin n_fail++; $display("FAIL single_pixel got=%h exp=%h", {bus.x, bus.y, bus.colour, bus.grant}, {9'd5, 8'd7, 3'b100, 2'b01}); end
      end
      served = bus.r0_ready;
      if (served) acc_at = i;
      step();
      if (served) bus.r0_valid = 0;
    end
    n_chk++; if (acc_at != 1) begin n_fail++; $display("FAIL single_first_slot got=%0d exp=1", acc_at); end
    n_chk++; if (nplot != 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", nplot); end
  endtask

  task automatic test_alternate();
    logic [1:0] gq[$];
    logic [1:0] r;
    int last_plot = -10, nplot = 0, bad = 0;
    apply_reset();
    bus.r0_valid = 1; bus.r0_x = 9'($urandom_range(XM - 1)); bus.r0_y = 8'($urandom_range(YM - 1)); bus.r0_colour = 3'($urandom);
    bus.r1_valid = 1; bus.r1_x = 9'($urandom_range(XM - 1)); bus.r1_y = 8'($urandom_range(YM - 1)); bus.r1_colour = 3'($urandom);
    for (int i = 0; i < 18; i++) begin
      #1;
      r = {bus.r1_ready, bus.r0_ready};
      n_chk++; if (r !== exp_ready()) begin n_fail++; $display("FAIL alt_ready cyc=%0d got=%b exp=%b", cyc, r, exp_ready()); end
      n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL alt_bus cyc=%0d got=%h exp=%h", cyc, got_bus(), exp_bus()); end
      if (r != 2'b00 && i < 16) gq.push_back(r);
      if (bus.plot) begin
        n_chk++; if (i - last_plot < 2) begin n_fail++; $display("FAIL alt_cadence gap=%0d exp>=2", i - last_plot); end
        last_plot = i; nplot++;
      end
      step();
      if (r[0]) begin bus.r0_x = 9'($urandom_range(XM - 1)); bus.r0_y = 8'($urandom_range(YM - 1)); bus.r0_colour = 3'($urandom); end
      if (r[1]) begin bus.r1_x = 9'($urandom_range(XM - 1)); bus.r1_y = 8'($urandom_range(YM - 1)); bus.r1_colour = 3'($urandom); end
    end
    foreach (gq[k]) if (gq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) bad++;
    n_chk++; if (gq.size() != 8 || bad != 0) begin n_fail++; $display("FAIL alt_order grants=%0d bad=%0d exp=8 bad=0", gq.size(), bad); end
    n_chk++; if (nplot != 8) begin n_fail++; $display("FAIL alt_plots got=%0d exp=8", nplot); end
  endtask

  task automatic test_random();
    logic [1:0] r;
    int w0 = 0, w1 = 0, last_plot = -10, t = 0;
    bit gen = 1;
    while (t < 440 && (gen || bus.r0_valid || bus.r1_valid)) begin
      #1;
      r = {bus.r1_ready, bus.r0_ready};
      n_chk++; if (r !== exp_ready()) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, r, exp_ready()); end
      n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL rand_bus cyc=%0d got=%h exp=%h", cyc, got_bus(), exp_bus()); end
      if (bus.plot) begin
        n_chk++; if (t - last_plot < 2) begin n_fail++; $display("FAIL rand_cadence gap=%0d exp>=2", t - last_plot); end
        last_plot = t;
      end
      if (m_phase) begin
        if (r[0]) begin n_chk++; if (w0 > 2) begin n_fail++; $display("FAIL rand_starve0 waited=%0d exp<=2", w0); end w0 = 0; end
        else if (bus.r0_valid) w0++;
        if (r[1]) begin n_chk++; if (w1 > 2) begin n_fail++; $display("FAIL rand_starve1 waited=%0d exp<=2", w1); end w1 = 0; end
        else if (bus.r1_valid) w1++;
      end
      step();
      t++;
      if (t >= 400) gen = 0;
      if (!bus.r0_valid || r[0]) begin
        bus.r0_valid = gen && ($urandom_range(99) < 60);
        bus.r0_x = 9'($urandom_range(XM - 1)); bus.r0_y = 8'($urandom_range(YM - 1)); bus.r0_colour = 3'($urandom);
      end
      if (!bus.r1_valid || r[1]) begin
        bus.r1_valid = gen && ($urandom_range(99) < 60);
        bus.r1_x = 9'($urandom_range(XM - 1)); bus.r1_y = 8'($urandom_range(YM - 1)); bus.r1_colour = 3'($urandom);
      end
    end
    n_chk++; if (bus.r0_valid || bus.r1_valid) begin n_fail++; $display("FAIL rand_drain timeout r0=%b r1=%b exp=00", bus.r0_valid, bus.r1_valid); end
  endtask

  task automatic test_clear();
    int nclr = 0, t = 0;
    bit done = 0, served;
    bus.clear_start = 1;
    #1;
    n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL clr_start_bus got=%h exp=%h", got_bus(), exp_bus()); end
    step();
    bus.clear_start = 0;
    n_chk++; if (bus.clear_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise got=%b exp=1", bus.clear_busy); end
    bus.r0_valid = 1; bus.r0_x = 9'd3; bus.r0_y = 8'd4; bus.r0_colour = 3'b010;
    while (!done && t < 2 * NPIX + 40) begin
      #1;
      n_chk++; if ({bus.r1_ready, bus.r0_ready} !== exp_ready()) begin n_fail++; $display("FAIL clr_ready cyc=%0d got=%b exp=%b", cyc, {bus.r1_ready, bus.r0_ready}, exp_ready()); end
      n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL clr_bus cyc=%0d got=%h exp=%h", cyc, got_bus(), exp_bus()); end
      if (bus.clear_busy && (bus.r0_ready || bus.r1_ready)) begin n_chk++; n_fail++; $display("FAIL clr_ready_busy got=%b exp=00", {bus.r1_ready, bus.r0_ready}); end
      if (bus.plot && bus.grant == 2'b00) begin
        if (nclr == 0) begin n_chk++; if ({bus.x, bus.y, bus.colour} !== {9'd0, 8'd0, 3'b111}) begin n_fail++; $display("FAIL clr_first got=%h exp=%h", {bus.x, bus.y, bus.colour}, {9'd0, 8'd0, 3'b111}); end end
        if (nclr == XM - 1) begin n_chk++; if ({bus.x, bus.y} !== {9'(XM - 1), 8'd0}) begin n_fail++; $display("FAIL clr_eol got=%h exp=%h", {bus.x, bus.y}, {9'(XM - 1), 8'd0}); end end
        if (nclr == XM) begin n_chk++; if ({bus.x, bus.y} !== {9'd0, 8'd1}) begin n_fail++; $display("FAIL clr_wrap got=%h exp=%h", {bus.x, bus.y}, {9'd0, 8'd1}); end end
        if (nclr == NPIX - 1) begin n_chk++; if ({bus.x, bus.y, bus.colour, bus.clear_busy} !== {9'(XM - 1), 8'(YM - 1), 3'b111, 1'b0}) begin n_fail++; $display("FAIL clr_last got=%h exp=%h", {bus.x, bus.y, bus.colour, bus.clear_busy}, {9'(XM - 1), 8'(YM - 1), 3'b111, 1'b0}); end end
        nclr++;
      end
      bus.clear_start = (t == 60);
      served = bus.r0_ready;
      step();
      bus.clear_start = 0;
      if (served) begin bus.r0_valid = 0; done = (nclr == NPIX); end
      t++;
    end
    n_chk++; if (!done || nclr != NPIX) begin n_fail++; $display("FAIL clr_count got=%0d exp=%0d done=%b", nclr, NPIX, done); end
  endtask

  task automatic test_reset_mid_clear();
    int nclr = 0, t = 0, n1 = 0, nc2 = 0;
    bit served;
    bus.clear_start = 1;
    step();
    bus.clear_start = 0;
    while (nclr < 100 && t < 400) begin
      if (bus.plot && bus.grant == 2'b00) nclr++;
      step();
      t++;
    end
    n_chk++; if (nclr < 100) begin n_fail++; $display("FAIL rmc_progress got=%0d exp=100", nclr); end
    rst_n = 0;
    #1;
    n_chk++; if ({bus.plot, bus.clear_busy} !== 2'b00) begin n_fail++; $display("FAIL rmc_async got=%b exp=00", {bus.plot, bus.clear_busy}); end
    apply_reset();
    bus.r1_valid = 1; bus.r1_x = 9'd10; bus.r1_y = 8'd20; bus.r1_colour = 3'b101;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_chk++; if ({bus.r1_ready, bus.r0_ready} !== exp_ready()) begin n_fail++; $display("FAIL rmc_ready cyc=%0d got=%b exp=%b", cyc, {bus.r1_ready, bus.r0_ready}, exp_ready()); end
      n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL rmc_bus cyc=%0d got=%h exp=%h", cyc, got_bus(), exp_bus()); end
      if (bus.plot && bus.grant == 2'b10) n1++;
      if (bus.plot && bus.grant == 2'b00) nc2++;
      served = bus.r1_ready;
      step();
      if (served) bus.r1_valid = 0;
    end
    n_chk++; if (n1 != 1 || nc2 != 0) begin n_fail++; $display("FAIL rmc_after r1_plots=%0d clear_plots=%0d exp=1,0", n1, nc2); end
  endtask

  task automatic test_clear_with_r1();
    int nplot = 0;
    if (!m_phase) step();
    bus.r1_valid = 1; bus.r1_x = 9'd1; bus.r1_y = 8'd2; bus.r1_colour = 3'b110;
    bus.clear_start = 1;
    #1;
    n_chk++; if ({bus.r1_ready, bus.r0_ready} !== 2'b10) begin n_fail++; $display("FAIL cwr_ready got=%b exp=10", {bus.r1_ready, bus.r0_ready}); end
    step();
    bus.clear_start = 0; bus.r1_valid = 0;
    n_chk++; if ({bus.plot, bus.grant, bus.x, bus.y, bus.colour} !== {1'b1, 2'b10, 9'd1, 8'd2, 3'b110}) begin n_fail++; $display("FAIL cwr_r1_plot got=%h exp=%h", {bus.plot, bus.grant, bus.x, bus.y, bus.colour}, {1'b1, 2'b10, 9'd1, 8'd2, 3'b110}); end
    for (int t = 0; t < 2 * NPIX + 20; t++) begin
      n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL cwr_bus cyc=%0d got=%h exp=%h", cyc, got_bus(), exp_bus()); end
      if (bus.plot) nplot++;
      bus.clear_start = (t == 40);
      step();
      bus.clear_start = 0;
    end
    n_chk++; if (nplot != NPIX + 1) begin n_fail++; $display("FAIL cwr_total got=%0d exp=%0d", nplot, NPIX + 1); end
  endtask

  task automatic test_oob();
    bit acc = 0, prev = 0, served;
    bus.r0_valid = 1; bus.r0_x = 9'(XM); bus.r0_y = 8'd0; bus.r0_colour = 3'b001;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++; if (got_bus() !== exp_bus()) begin n_fail++; $display("FAIL oob_bus cyc=%0d got=%h exp=%h", cyc, got_bus(), exp_bus()); end
      if (prev) begin
        n_chk++;
        if (BCHK ? ({bus.plot, bus.oob_drop} !== 2'b01) : ({bus.plot, bus.oob_drop, bus.x} !== {2'b10, 9'(XM)})) begin
          n_fail++; $display("FAIL oob_result got=%b,%b,x=%0d bounds=%b", bus.plot, bus.oob_drop, bus.x, BCHK);
        end
      end
      served = bus.r0_ready;
      if (served) acc = 1;
      step();
      prev = served;
      if (served) bus.r0_valid = 0;
    end
    n_chk++; if (!acc) begin n_fail++; $display("FAIL oob_accept got=0 exp=1"); end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_clear_with_r1();
    test_oob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
